// File: rtl/image_seq_pkg.sv
// Shared types and constants for the image sequencer and its fade scaler.
// Optional feature macro used by the top: IMAGE_SEQ_AUTO_ADVANCE_EN.
package image_seq_pkg;

  localparam int LEVEL_MAX = 16;
  localparam int LEVEL_W   = 5;
  localparam int CH_W      = 4;
  localparam int RGB_W     = 3 * CH_W;

  typedef enum logic [1:0] {
    SHOW     = 2'd0,
    FADE_OUT = 2'd1,
    SWITCH   = 2'd2,
    FADE_IN  = 2'd3
  } state_e;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/image_fade_scaler.sv
// Combinational brightness scaler for one colour channel: (c * level) >> 4.
// level is 0..16, so level 16 is unity gain and level 0 is black.
module image_fade_scaler
  import image_seq_pkg::*;
(
  input  logic [CH_W-1:0]    c_i,
  input  logic [LEVEL_W-1:0] level_i,
  output logic [CH_W-1:0]    c_o
);

  logic [CH_W+LEVEL_W-1:0] prod;

  assign prod = {{LEVEL_W{1'b0}}, c_i} * {{CH_W{1'b0}}, level_i};
  assign c_o  = CH_W'(prod >> 4);

endmodule

// File: rtl/image_sequencer.sv
// Shares the VGA RGB output between pattern generators, fading between them at frame boundaries.
// Define IMAGE_SEQ_AUTO_ADVANCE_EN to let a dwell timer advance sources automatically.
module image_sequencer
  import image_seq_pkg::*;
#(
  parameter int NUM_SOURCES          = 2,
  parameter int DWELL_FRAMES         = 300,
  parameter int FADE_FRAMES_PER_STEP = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             frame_start,
  input  logic                             next_req,
  input  logic [NUM_SOURCES*RGB_W-1:0]     src_rgb,
  output logic [31:0]                      frame,
  output logic [$clog2(NUM_SOURCES)-1:0]   sel,
  output logic                             fading,
  output logic [CH_W-1:0]                  r,
  output logic [CH_W-1:0]                  g,
  output logic [CH_W-1:0]                  b
);

  localparam int SEL_W  = $clog2(NUM_SOURCES);
  localparam int STEP_W = $clog2(FADE_FRAMES_PER_STEP + 1);

  localparam logic [SEL_W-1:0]   SEL_LAST  = SEL_W'(NUM_SOURCES - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(FADE_FRAMES_PER_STEP - 1);
  localparam logic [LEVEL_W-1:0] LVL_MAX   = LEVEL_W'(LEVEL_MAX);

  state_e              state_q, state_d;
  logic [31:0]         frame_q;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                pending_q, pending_d;
  logic                advance;
  rgb_t                rgb_q;
  rgb_t                src_sel;
  rgb_t                scaled;
  rgb_t                src_arr [NUM_SOURCES];

`ifdef IMAGE_SEQ_AUTO_ADVANCE_EN
  localparam int DWELL_W = $clog2(DWELL_FRAMES + 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);

  logic [DWELL_W-1:0] dwell_q, dwell_d;

  assign advance = pending_q || next_req || (dwell_q == DWELL_LAST);
`else
  assign advance = pending_q || next_req;
`endif

  // State register (also holds all frame-synchronous datapath registers)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SHOW;
      frame_q   <= '0;
      sel_q     <= '0;
      level_q   <= LVL_MAX;
      step_q    <= '0;
      pending_q <= 1'b0;
      rgb_q     <= '0;
`ifdef IMAGE_SEQ_AUTO_ADVANCE_EN
      dwell_q   <= '0;
`endif
    end else begin
      if (frame_start) begin
        frame_q <= frame_q + 32'd1;
      end
      state_q   <= state_d;
      sel_q     <= sel_d;
      level_q   <= level_d;
      step_q    <= step_d;
      pending_q <= pending_d;
      rgb_q     <= scaled;
`ifdef IMAGE_SEQ_AUTO_ADVANCE_EN
      dwell_q   <= dwell_d;
`endif
    end
  end

  // Next-state logic; every visible change is gated by frame_start
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    level_d   = level_q;
    step_d    = step_q;
    pending_d = pending_q;
`ifdef IMAGE_SEQ_AUTO_ADVANCE_EN
    dwell_d   = dwell_q;
`endif
    case (state_q)
      SHOW: begin
        if (next_req) begin
          pending_d = 1'b1;
        end
        if (frame_start) begin
`ifdef IMAGE_SEQ_AUTO_ADVANCE_EN
          dwell_d = dwell_q + 1'b1;
`endif
          if (advance) begin
            state_d   = FADE_OUT;
            pending_d = 1'b0;
            step_d    = '0;
`ifdef IMAGE_SEQ_AUTO_ADVANCE_EN
            dwell_d   = '0;
`endif
          end
        end
      end
      FADE_OUT: begin
        if (frame_start) begin
          if (step_q == STEP_LAST) begin
            step_d  = '0;
            level_d = level_q - 1'b1;
            if (level_q == LEVEL_W'(1)) begin
              state_d = SWITCH;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      SWITCH: begin
        if (frame_start) begin
          sel_d   = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
          step_d  = '0;
          state_d = FADE_IN;
        end
      end
      FADE_IN: begin
        if (frame_start) begin
          if (step_q == STEP_LAST) begin
            step_d  = '0;
            level_d = level_q + 1'b1;
            if (level_q == LVL_MAX - 1'b1) begin
              state_d = SHOW;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = SHOW;
        level_d = LVL_MAX;
      end
    endcase
  end

  // Output logic
  always_comb begin
    fading = (state_q != SHOW);
  end

  for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
    assign src_arr[gi] = src_rgb[gi*RGB_W +: RGB_W];
  end

  assign src_sel = src_arr[sel_q];

  image_fade_scaler u_scale_r (.c_i(src_sel.r), .level_i(level_q), .c_o(scaled.r));
  image_fade_scaler u_scale_g (.c_i(src_sel.g), .level_i(level_q), .c_o(scaled.g));
  image_fade_scaler u_scale_b (.c_i(src_sel.b), .level_i(level_q), .c_o(scaled.b));

  assign frame = frame_q;
  assign sel   = sel_q;
  assign r     = rgb_q.r;
  assign g     = rgb_q.g;
  assign b     = rgb_q.b;

endmodule

// File: doc/image_sequencer.md
Name: image_sequencer

Overview:
- Scheduler that shares the VGA RGB output between NUM_SOURCES pattern generators: checkerboard, fractal and any later generators.
- Owns the frame counter that feeds every generator's frame input.
- Picks the active generator and switches at frame boundaries with a fade-out/fade-in.
- Sits between the generator instances and the VGA output registers.

Parameters:
- NUM_SOURCES, 2, number of pattern generators multiplexed; must be ≥2.
- DWELL_FRAMES, 300, frames a source is shown at full brightness before auto-advance; must be ≥1.
- FADE_FRAMES_PER_STEP, 2, frames held at each brightness level during a fade; must be ≥1.

Ports:
- clk  input  1  pixel clock.
- rst_n  input  1  asynchronous, active-low reset.
- frame_start  input  1  single-cycle pulse at the start of vertical blank.
- next_req  input  1  single-cycle pulse requesting advance to the next source.
- src_rgb  input  NUM_SOURCES*12  source k occupies bits [12k+11:12k] as {r,g,b}, 4 bits each; already registered by the generator.
- frame  output  32  frame counter fed to all generators.
- sel  output  $clog2(NUM_SOURCES)  index of the active source.
- fading  output  1  high in FADE_OUT, SWITCH and FADE_IN.
- r, g, b  output  4 each  scaled colour of the active source.

Behaviour:
- Reset (async assert, sync release):
  - frame=0, sel=0, level=16, state=SHOW, dwell=0, step_cnt=0, pending=0.
  - r=g=b=0, fading=0.
- frame increments by 1 on every frame_start and wraps at 2^32. It is never cleared except by reset.
- Pixel path:
  - r/g/b <= (c*level)>>4 per channel, where c is the selected source's channel.
  - c*level is a 4×5 → 9-bit product; take bits [7:4]. level=16 passes c unchanged; level=0 gives 0.
  - Latency is exactly 1 clk from src_rgb to r/g/b.
- level is 5 bits, range 0..16. level, sel and state change only in the cycle that frame_start is high, so they never change mid-frame.
- FSM:
  - SHOW:
    - level=16.
    - On frame_start, dwell++.
    - next_req sets pending; next_req and frame_start in the same cycle also count.
    - On frame_start with (pending or dwell reaches DWELL_FRAMES): go to FADE_OUT and clear dwell, pending and step_cnt.
  - FADE_OUT:
    - On each frame_start, step_cnt++.
    - When step_cnt reaches FADE_FRAMES_PER_STEP: clear step_cnt and level--.
    - The frame_start at which level becomes 0 moves the FSM to SWITCH.
  - SWITCH: on the next frame_start, sel <= (sel==NUM_SOURCES-1) ? 0 : sel+1 and go to FADE_IN. level stays 0, so one full black frame is shown.
  - FADE_IN:
    - Mirror of FADE_OUT, with level++.
    - Reaching 16 moves the FSM to SHOW with dwell=0.
- next_req is ignored outside SHOW; it is not queued.
- Total fade time is 16*FADE_FRAMES_PER_STEP*2 + 1 frames.
- A reset mid-fade returns immediately to SHOW, sel=0, level=16.
- An out-of-range sel is impossible; the mux selects by sel directly.

Optional Feature:
- Macro: IMAGE_SEQ_AUTO_ADVANCE_EN.
- Defined: the dwell timer triggers advance as described above.
- Undefined:
  - The dwell counter is not instantiated.
  - SHOW leaves only on pending.
  - A source is displayed indefinitely until next_req.
  - DWELL_FRAMES is unused.

Decomposition:
- Package image_seq_pkg:
  - state enum {SHOW, FADE_OUT, SWITCH, FADE_IN}
  - LEVEL_MAX=16, LEVEL_W=5, CH_W=4
  - an rgb struct {r,g,b}
- Sub-module image_fade_scaler: combinational, per-channel (c, level) → scaled c. Instantiated three times.

Test Plan:
- Reset then 5 frame_start pulses, with src0=12'hF00 and src1=12'h0F0 → frame=5, sel=0, r=4'hF, g=0, b=0 one clk after each src change; fading=0.
- next_req, then frame_start, with FADE_FRAMES_PER_STEP=2 →
  - fading=1 and level steps 16→0 over 32 frames; r with c=F follows F,E,D…,0.
  - One black SWITCH frame, then sel=1.
  - Level ramps back to 16 over 32 frames; output 12'h0F0.
- next_req and frame_start asserted in the same cycle in SHOW → FADE_OUT entered that cycle. Further next_req pulses during the fade have no effect: sel advances by exactly 1.
- NUM_SOURCES=3, three advances from sel=0 → sel sequence 1,2,0 (wrap).
- With IMAGE_SEQ_AUTO_ADVANCE_EN and DWELL_FRAMES=4 → FADE_OUT begins on the 4th frame_start after SHOW entry. Without the macro, no transition after 1000 frames.
- rst_n asserted mid-FADE_IN, at level=7 and sel=1 → asynchronously r=g=b=0, sel=0, fading=0. After release, output is the unscaled src0.
